mult_sequencer: RTL and testbench
=================================

// Module: mult_sequencer
// PURPOSE
//  Multi-cycle MULT/MULTU controller that reuses the shared 32-bit ALU (2-bit aluctr: 00 add, 01 sub, 10 or, 11 lui).
//  Sits between the single-cycle core's ALU operand muxes and the ALU, and owns the ALU while a multiply runs.
//  Stalls the core until the 64-bit product is ready, then presents it on hi/lo with a one-cycle done strobe.
//  Shift-add algorithm, one ALU add per iteration; signed operands handled by ALU negate steps before and after.
// PARAMETERS
//  WIDTH   32  operand width; must equal ALU width; ITER runs WIDTH cycles
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      synchronous, active-high
//  start      in   1      decoded MULT/MULTU in the current instruction
//  is_signed  in   1      1 = MULT, 0 = MULTU; sampled with start
//  rs_val     in   WIDTH  multiplicand; sampled with start
//  rt_val     in   WIDTH  multiplier; sampled with start
//  core_a     in   WIDTH  core ALU operand a (passed through when idle)
//  core_b     in   WIDTH  core ALU operand b
//  core_ctr   in   2      core aluctr
//  alu_out    in   WIDTH  ALU result (aluout)
//  alu_a      out  WIDTH  to ALU a
//  alu_b      out  WIDTH  to ALU b
//  alu_ctr    out  2      to ALU aluctr
//  stall      out  1      hold PC/regfile writes
//  done       out  1      hi/lo valid, one cycle
//  hi         out  WIDTH  product[63:32]
//  lo         out  WIDTH  product[31:0]
// BEHAVIOUR
//  States: IDLE, NEG_A, NEG_B, ITER, NEG_LO, NEG_HI, DEC_HI, DONE. Reset (any state) -> IDLE; hi=lo=0, done=0, cnt=0.
//  ALU mux: IDLE/DONE -> alu_* = core_* (combinational); all other states -> sequencer-driven.
//  stall = (start & (IDLE|DONE)) | (state not IDLE/DONE); combinational so the start cycle itself is held.
//  Accept: start in IDLE or DONE -> latch mcand=rs_val, acc_lo=rt_val, acc_hi=0, neg=is_signed&(rs[31]^rt[31]).
//   Signed -> NEG_A; unsigned -> ITER. start in any other state is ignored.
//  NEG_A: alu = 0 - mcand if signed & mcand[31], else mcand + 0; mcand<=alu_out. -> NEG_B.
//  NEG_B: same on acc_lo with rt sign. -> ITER.
//  ITER (cnt 0..WIDTH-1): if acc_lo[0]: alu = acc_hi + mcand (ctr 00), c = (alu_out < acc_hi) unsigned;
//   else alu = acc_hi + 0, c=0. {acc_hi,acc_lo} <= {c, alu_out, acc_lo[WIDTH-1:1]}. cnt==WIDTH-1 ->
//   NEG_LO if signed, else DONE.
//  NEG_LO: alu = neg ? 0-acc_lo : acc_lo+0; lo_nz <= (acc_lo!=0); acc_lo<=alu_out. -> NEG_HI.
//  NEG_HI: alu = neg ? 0-acc_hi : acc_hi+0; acc_hi<=alu_out. -> DEC_HI.
//  DEC_HI: alu = (neg & lo_nz) ? acc_hi-1 : acc_hi+0; acc_hi<=alu_out. -> DONE.
//  DONE: hi<=acc_hi, lo<=acc_lo registered on entry; done=1 for exactly this cycle; stall=0 unless start.
//   start here re-launches (back-to-back); otherwise -> IDLE.
//  Latency (start cycle = 0): MULTU done at cycle WIDTH+1 (33); MULT done at WIDTH+6 (38). Fixed, data-independent.
//  hi/lo hold last product until next DONE or reset. alu_ctr never 10/11 while owned. -2^31 magnitude = 2^31 unsigned.
// STRUCTURE
//  Shared package mips_pkg: ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_OR=2'b10, ALU_LUI=2'b11; state encoding localparams.
//  Single module, no sub-modules; ALU instantiated outside, at datapath level.
// TESTING
//  MULTU 0xFFFFFFFF*0xFFFFFFFF -> done at cycle 33, hi=0xFFFFFFFE lo=0x00000001 (carry path).
//  MULT -3*5 -> done at cycle 38, hi=0xFFFFFFFF lo=0xFFFFFFF1; MULT -4*-4 -> hi=0 lo=0x10.
//  MULT 0x80000000*0x80000000 -> hi=0x40000000 lo=0; MULT 0*-7 -> hi=0 lo=0 (lo_nz=0 path).
//  Idle pass-through: core_a=5 core_b=3 core_ctr=01 -> alu_a=5 alu_b=3 alu_ctr=01 same cycle; stall=0.
//  start re-asserted mid-ITER -> ignored, result unchanged; start in DONE -> second product 33 cycles later.
//  reset asserted at ITER cnt=10 -> next cycle IDLE, stall=0, done=0, hi=lo=0.

Source files
------------

// File: rtl/mult_sequencer_pkg.sv
// Shared definitions for the multiply sequencer.
//   ALU_*   : 2-bit aluctr encodings of the shared ALU (add, sub, or, lui)
//   state_t : sequencer FSM states
package mult_sequencer_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_LUI = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEG_A,
        S_NEG_B,
        S_ITER,
        S_NEG_LO,
        S_NEG_HI,
        S_DEC_HI,
        S_DONE
    } state_t;

endpackage

// File: rtl/mult_sequencer_if.sv
// Bundle between the core, the multiply sequencer and the shared ALU.
//   core side : start, is_signed, rs_val, rt_val, core_a/b/ctr in; stall, done, hi, lo out
//   ALU side  : alu_a/b/ctr out to the ALU, alu_out back from the ALU
// master = core/datapath side, slave = sequencer.
interface mult_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_b;
    logic [1:0]       core_ctr;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_ctr;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, rs_val, rt_val, core_a, core_b, core_ctr, alu_out,
        input  alu_a, alu_b, alu_ctr, stall, done, hi, lo
    );

    modport slave (
        input  start, is_signed, rs_val, rt_val, core_a, core_b, core_ctr, alu_out,
        output alu_a, alu_b, alu_ctr, stall, done, hi, lo
    );
endinterface

// File: rtl/mult_sequencer.sv
// Multi-cycle MULT/MULTU controller that borrows the shared ALU.
// Shift-add, one ALU add per iteration; signed operands are made positive
// by ALU negate steps before the loop and the 64-bit result is negated after.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of mult_sequencer_if (operands, ALU mux, stall/done, hi/lo)
import mult_sequencer_pkg::*;

module mult_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input logic            clk,
    input logic            reset,
    mult_sequencer_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    state_t           state, state_n;
    logic [WIDTH-1:0] mcand, mcand_n;
    logic [WIDTH-1:0] acc_hi, acc_hi_n;
    logic [WIDTH-1:0] acc_lo, acc_lo_n;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [CW-1:0]    cnt, cnt_n;
    logic             sgn, sgn_n;
    logic             neg, neg_n;
    logic             lo_nz, lo_nz_n;
    logic             owned, accept, carry;
    logic [WIDTH-1:0] sa, sb;
    logic [1:0]       sctr;

    assign owned  = !(state == S_IDLE || state == S_DONE);
    assign accept = bus.start && !owned;

    // Operand selection kept apart from next-state logic so the
    // alu_a -> alu_out -> next-state path is not a combinational loop.
    always_comb begin
        sa   = '0;
        sb   = '0;
        sctr = ALU_ADD;
        unique case (state)
            S_NEG_A: begin
                if (sgn && mcand[WIDTH-1]) begin
                    sb   = mcand;
                    sctr = ALU_SUB;
                end else begin
                    sa = mcand;
                end
            end
            S_NEG_B: begin
                if (sgn && acc_lo[WIDTH-1]) begin
                    sb   = acc_lo;
                    sctr = ALU_SUB;
                end else begin
                    sa = acc_lo;
                end
            end
            S_ITER: begin
                sa = acc_hi;
                sb = acc_lo[0] ? mcand : '0;
            end
            S_NEG_LO: begin
                sa   = neg ? '0 : acc_lo;
                sb   = neg ? acc_lo : '0;
                sctr = neg ? ALU_SUB : ALU_ADD;
            end
            S_NEG_HI: begin
                sa   = neg ? '0 : acc_hi;
                sb   = neg ? acc_hi : '0;
                sctr = neg ? ALU_SUB : ALU_ADD;
            end
            S_DEC_HI: begin
                // Two's complement of {hi,lo}: hi = -hi - (lo != 0)
                sa   = acc_hi;
                sb   = (neg && lo_nz) ? WIDTH'(1) : '0;
                sctr = (neg && lo_nz) ? ALU_SUB : ALU_ADD;
            end
            default: ;
        endcase

        bus.alu_a   = owned ? sa   : bus.core_a;
        bus.alu_b   = owned ? sb   : bus.core_b;
        bus.alu_ctr = owned ? sctr : bus.core_ctr;
        bus.stall   = accept || owned;
        bus.done    = (state == S_DONE);
        bus.hi      = hi_q;
        bus.lo      = lo_q;
    end

    always_comb begin
        state_n  = state;
        mcand_n  = mcand;
        acc_hi_n = acc_hi;
        acc_lo_n = acc_lo;
        cnt_n    = cnt;
        sgn_n    = sgn;
        neg_n    = neg;
        lo_nz_n  = lo_nz;
        carry    = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    mcand_n  = bus.rs_val;
                    acc_lo_n = bus.rt_val;
                    acc_hi_n = '0;
                    cnt_n    = '0;
                    sgn_n    = bus.is_signed;
                    neg_n    = bus.is_signed && (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
                    state_n  = bus.is_signed ? S_NEG_A : S_ITER;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_NEG_A: begin
                mcand_n = bus.alu_out;
                state_n = S_NEG_B;
            end
            S_NEG_B: begin
                acc_lo_n = bus.alu_out;
                state_n  = S_ITER;
            end
            S_ITER: begin
                // Unsigned wrap of the add recovers the carry out of bit WIDTH-1.
                carry                = acc_lo[0] && (bus.alu_out < acc_hi);
                {acc_hi_n, acc_lo_n} = {carry, bus.alu_out, acc_lo[WIDTH-1:1]};
                cnt_n                = cnt + 1'b1;
                if (cnt == CW'(WIDTH - 1))
                    state_n = sgn ? S_NEG_LO : S_DONE;
            end
            S_NEG_LO: begin
                lo_nz_n  = (acc_lo != '0);
                acc_lo_n = bus.alu_out;
                state_n  = S_NEG_HI;
            end
            S_NEG_HI: begin
                acc_hi_n = bus.alu_out;
                state_n  = S_DEC_HI;
            end
            S_DEC_HI: begin
                acc_hi_n = bus.alu_out;
                state_n  = S_DONE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            cnt    <= '0;
            sgn    <= 1'b0;
            neg    <= 1'b0;
            lo_nz  <= 1'b0;
        end else begin
            state  <= state_n;
            mcand  <= mcand_n;
            acc_hi <= acc_hi_n;
            acc_lo <= acc_lo_n;
            cnt    <= cnt_n;
            sgn    <= sgn_n;
            neg    <= neg_n;
            lo_nz  <= lo_nz_n;
            if (state_n == S_DONE) begin
                hi_q <= acc_hi_n;
                lo_q <= acc_lo_n;
            end
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
module tb_mult_sequencer;
    import mult_sequencer_pkg::*;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mult_sequencer_if #(.WIDTH(W)) bus ();

    mult_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Shared ALU model
    always_comb begin
        case (bus.alu_ctr)
            ALU_ADD: bus.alu_out = bus.alu_a + bus.alu_b;
            ALU_SUB: bus.alu_out = bus.alu_a - bus.alu_b;
            ALU_OR:  bus.alu_out = bus.alu_a | bus.alu_b;
            default: bus.alu_out = {bus.alu_b[15:0], 16'h0000};
        endcase
    end

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        string       name;
    } vec_t;

    function automatic logic [63:0] ref_prod(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return 64'(a) * 64'(b);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Launch from the current (settled) cycle, wait for done, check latency/result.
    // poke > 0 re-asserts start with junk operands at that cycle (must be ignored).
    task automatic do_mult(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int poke, input string name);
        int   cyc;
        logic bad;
        bus.start     = 1'b1;
        bus.is_signed = sg;
        bus.rs_val    = a;
        bus.rt_val    = b;
        #1;
        chk({name, "_stall_start"}, 64'(bus.stall), 64'd1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        bad = 1'b0;
        while (!bus.done && cyc < 60) begin
            if (bus.stall !== 1'b1 || bus.alu_ctr[1] !== 1'b0) bad = 1'b1;
            if (cyc == poke) begin
                bus.start     = 1'b1;
                bus.is_signed = ~sg;
                bus.rs_val    = $urandom;
                bus.rt_val    = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        #1;
        chk({name, "_owned"}, 64'(bad), 64'd0);
        chk({name, "_latency"}, 64'(cyc), sg ? 64'd38 : 64'd33);
        chk({name, "_prod"}, {bus.hi, bus.lo}, exp);
        chk({name, "_stall_done"}, 64'(bus.stall), 64'd0);
    endtask

    vec_t vecs[$];

    initial begin
        logic [63:0] last;
        logic        sg;
        logic [31:0] a, b;

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.rs_val    = '0;
        bus.rt_val    = '0;
        bus.core_a    = '0;
        bus.core_b    = '0;
        bus.core_ctr  = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("reset_stall", 64'(bus.stall), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);

        // Idle pass-through
        bus.core_a   = 32'd5;
        bus.core_b   = 32'd3;
        bus.core_ctr = 2'b01;
        #1;
        chk("pass_a", 64'(bus.alu_a), 64'd5);
        chk("pass_b", 64'(bus.alu_b), 64'd3);
        chk("pass_ctr", 64'(bus.alu_ctr), 64'd1);
        chk("pass_stall", 64'(bus.stall), 64'd0);
        @(posedge clk); #1;

        // Directed vectors, chained back-to-back (each launch happens in the DONE cycle)
        vecs.push_back('{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, "multu_max"});
        vecs.push_back('{1'b1, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1, "mult_m3x5"});
        vecs.push_back('{1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC, 64'h00000000_00000010, "mult_m4xm4"});
        vecs.push_back('{1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, "mult_min2"});
        vecs.push_back('{1'b1, 32'h00000000, 32'hFFFFFFF9, 64'h00000000_00000000, "mult_0xm7"});
        vecs.push_back('{1'b0, 32'h80000000, 32'h00000002, 64'h00000001_00000000, "multu_shift"});
        vecs.push_back('{1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000, "mult_maxxmin"});
        foreach (vecs[i]) begin
            do_mult(vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].exp, 0, vecs[i].name);
            if (i == 1) chk("b2b_done_strobe", 64'(bus.done), 64'd1);
        end

        // Result holds, done drops after one cycle
        last = {bus.hi, bus.lo};
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(bus.done), 64'd0);
        chk("hilo_hold", {bus.hi, bus.lo}, last);

        // start re-asserted mid-ITER is ignored
        do_mult(1'b0, 32'h12345678, 32'h9ABCDEF0, ref_prod(1'b0, 32'h12345678, 32'h9ABCDEF0), 10, "mid_start");
        do_mult(1'b1, 32'hDEADBEEF, 32'h00C0FFEE, ref_prod(1'b1, 32'hDEADBEEF, 32'h00C0FFEE), 20, "mid_start_s");

        // Random vectors against the reference model
        for (int i = 0; i < 24; i++) begin
            sg = 1'($urandom_range(1));
            a  = $urandom;
            b  = $urandom;
            if (i % 6 == 0) a = 32'h80000000;
            if (i % 7 == 0) b = 32'h0;
            if (i % 5 == 0) b = 32'hFFFFFFFF;
            do_mult(sg, a, b, ref_prod(sg, a, b), 0, $sformatf("rand%0d", i));
            if ($urandom_range(1) == 1) begin
                @(posedge clk); #1;
            end
        end

        // Reset in ITER at cnt=10 (cycle 11)
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.rs_val    = 32'h0000FFFF;
        bus.rt_val    = 32'h0000FFFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("pre_reset_hilo_nz", 64'({bus.hi, bus.lo} != 64'd0), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("mid_reset_stall", 64'(bus.stall), 64'd0);
        chk("mid_reset_done", 64'(bus.done), 64'd0);
        chk("mid_reset_hilo", {bus.hi, bus.lo}, 64'd0);
        bus.core_a   = 32'hA5A5A5A5;
        bus.core_b   = 32'h00000001;
        bus.core_ctr = 2'b00;
        #1;
        chk("mid_reset_pass", 64'(bus.alu_out), 64'hA5A5A5A6);
        @(posedge clk); #1;
        do_mult(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1, 0, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
